mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle iterative multiply/divide unit in the EX stage.
- Produces a 32-bit result as two 16-bit halves, with two destination register addresses, for the dual-write-port writeback path.
- Writeback mapping: result_lo → WriteData1/WriteReg1, result_hi → WriteData2/WriteReg2, write_op2 → WriteOP2.
- busy stalls the upstream pipeline while an operation iterates.

Parameters:
- WIDTH, 16, operand and result-half width.
- REG_AW, 4, register address width (16 registers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- op_a  in  WIDTH  multiplicand / dividend.
- op_b  in  WIDTH  multiplier / divisor.
- dest1  in  REG_AW  destination for the low half / quotient.
- dest2  in  REG_AW  destination for the high half / remainder.
- kill  in  1  pipeline flush; aborts an operation in flight.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle result-valid pulse.
- result_lo  out  WIDTH  product[15:0] or quotient.
- result_hi  out  WIDTH  product[31:16] or remainder.
- dest_reg1  out  REG_AW  latched dest1.
- dest_reg2  out  REG_AW  latched dest2.
- write_op2  out  1  equals done; second write port always used.
- div_by_zero  out  1  valid with done; set for DIVU/DIVS with op_b==0.

Behaviour:
- Reset (rst==0 at edge, synchronous, top priority):
  - state=IDLE; all outputs 0; internal accumulators and counter 0.
  - A reset in the middle of an operation discards it; no done.
- States:
  - IDLE → RUN on start.
  - RUN → DONE after 16 iterations.
  - DONE → RUN if start, else IDLE.
  - Any state → IDLE on kill. kill has priority over start.
- Accept edge:
  - Latch op, dest1/dest2.
  - Latch |op_a| and |op_b| (absolute values for signed ops only).
  - Latch sign-fix flags.
  - Clear 5-bit iteration counter.
- RUN: one iteration per edge.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - On the counter's 16th iteration: apply sign fix, register the result, go to DONE.
- Latency: start sampled at edge E0 → done high in the cycle following edge E16. That is 17 cycles of latency, and busy is high for 16 cycles.
- Back-to-back: start in the DONE cycle is accepted. done stays a single-cycle pulse and busy rises next cycle.
- done, result_lo/hi, dest_reg1/2, div_by_zero:
  - All change only on the DONE entry edge.
  - Results hold their value until the next DONE.
  - done, write_op2 and div_by_zero clear on leaving DONE.
- Signed rules:
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the sign of the dividend.
  - All arithmetic is modulo 2^WIDTH per half.
- Overflow: DIVS 0x8000 / 0xFFFF → quotient 0x8000, remainder 0x0000, div_by_zero=0.
- Divide by zero (either div op):
  - quotient 0xFFFF, remainder = op_a unmodified, div_by_zero=1.
  - Full latency applies unless the optional feature is enabled.
- kill:
  - In RUN: return to IDLE next edge; done never asserts; outputs keep previous result values.
  - In DONE: the already-registered done pulse is not retracted; the downstream stage qualifies it with its own flush.
  - In IDLE: no effect.
- start while in RUN is ignored. Upstream must hold the instruction while busy.

Optional Feature:
- Macro: MULDIV_EARLY_ZERO_EN.
- When defined, and op_b==0 at the accept edge:
  - Skip RUN and enter DONE directly, so done is high the cycle after the accept edge.
  - Multiply result is 0x0000/0x0000.
  - Divide result follows the divide-by-zero rules above.
- When undefined: all operations take the full 17-cycle latency.

Test Plan:
- MULU 0xFFFF×0xFFFF, dest1=3, dest2=4 → done at cycle 17; result_hi=0xFFFE, result_lo=0x0001; dest_reg1=3, dest_reg2=4; write_op2=1; busy high for exactly 16 cycles.
- MULS 0xFFFD(−3)×0x0005 → hi=0xFFFF, lo=0xFFF1. Then back-to-back start in the DONE cycle with DIVU 100/7 → quotient 0x000E, remainder 0x0002; second done exactly 17 cycles after the first.
- DIVS 0xFFF9(−7)/0x0002 → quotient 0xFFFD, remainder 0xFFFF. DIVS 0x8000/0xFFFF → quotient 0x8000, remainder 0x0000.
- DIVU 0x1234/0 → quotient 0xFFFF, remainder 0x1234, div_by_zero=1. Latency is 17 without the macro, 1 with MULDIV_EARLY_ZERO_EN.
- Start MULU, then kill at cycle 5 → busy low next cycle; no done; result_lo/hi retain the prior values. A start asserted together with kill is ignored.
- Start DIVU, then drive rst=0 for one edge at cycle 8 → all outputs 0, state IDLE; no done appears afterwards.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: 16-iteration shift-add multiplier / restoring divider with dual writeback.
// Optional macro MULDIV_EARLY_ZERO_EN: op_b==0 skips the iteration phase and finishes immediately.
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [REG_AW-1:0] dest1,
  input  logic [REG_AW-1:0] dest2,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result_lo,
  output logic [WIDTH-1:0]  result_hi,
  output logic [REG_AW-1:0] dest_reg1,
  output logic [REG_AW-1:0] dest_reg2,
  output logic              write_op2,
  output logic              div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_op;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_a_raw;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [4:0]          r_cnt;
  logic [REG_AW-1:0]   r_d1;
  logic [REG_AW-1:0]   r_d2;

  // Operand conditioning at the accept edge: magnitudes for signed ops only.
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  assign w_abs_a = (op[0] && op_a[WIDTH-1]) ? (WIDTH'(0) - op_a) : op_a;
  assign w_abs_b = (op[0] && op_b[WIDTH-1]) ? (WIDTH'(0) - op_b) : op_b;

  // Multiply step: {r_hi, r_lo} is the partial product, r_lo's LSB selects the add.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};

  // Divide step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;
  assign w_shift  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_b});
  assign w_diff   = w_shift[WIDTH-1:0] - r_b;
  assign w_div_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  assign w_hi_nxt = r_op[1] ? w_div_hi : w_mul_hi;
  assign w_lo_nxt = r_op[1] ? w_div_lo : w_mul_lo;

  // Sign fix and divide-by-zero override applied to the final iteration's values.
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_bzero;
  logic [WIDTH-1:0]   w_fin_lo;
  logic [WIDTH-1:0]   w_fin_hi;
  assign w_prod     = {w_hi_nxt, w_lo_nxt};
  assign w_prod_fix = r_neg_q ? ((2*WIDTH)'(0) - w_prod) : w_prod;
  assign w_quo      = r_neg_q ? (WIDTH'(0) - w_lo_nxt) : w_lo_nxt;
  assign w_rem      = r_neg_r ? (WIDTH'(0) - w_hi_nxt) : w_hi_nxt;
  assign w_bzero    = (r_b == '0);
  assign w_fin_lo   = r_op[1] ? (w_bzero ? {WIDTH{1'b1}} : w_quo) : w_prod_fix[WIDTH-1:0];
  assign w_fin_hi   = r_op[1] ? (w_bzero ? r_a_raw : w_rem) : w_prod_fix[2*WIDTH-1:WIDTH];

  assign busy      = (r_state == RUN);
  assign write_op2 = done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_a_raw     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_cnt       <= '0;
      r_d1        <= '0;
      r_d2        <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      dest_reg1   <= '0;
      dest_reg2   <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (kill) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start) begin
              r_op    <= op;
              r_d1    <= dest1;
              r_d2    <= dest2;
              r_a_raw <= op_a;
              r_b     <= w_abs_b;
              r_lo    <= w_abs_a;
              r_hi    <= '0;
              r_neg_q <= op[0] & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              r_neg_r <= op[0] & op[1] & op_a[WIDTH-1];
              r_cnt   <= '0;
`ifdef MULDIV_EARLY_ZERO_EN
              if (op_b == '0) begin
                r_state     <= DONE;
                done        <= 1'b1;
                div_by_zero <= op[1];
                result_lo   <= op[1] ? {WIDTH{1'b1}} : '0;
                result_hi   <= op[1] ? op_a : '0;
                dest_reg1   <= dest1;
                dest_reg2   <= dest2;
              end else begin
                r_state <= RUN;
              end
`else
              r_state <= RUN;
`endif
            end else begin
              r_state <= IDLE;
            end
          end
          RUN: begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd15) begin
              r_state     <= DONE;
              done        <= 1'b1;
              div_by_zero <= r_op[1] & w_bzero;
              result_lo   <= w_fin_lo;
              result_hi   <= w_fin_hi;
              dest_reg1   <= r_d1;
              dest_reg2   <= r_d2;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
`default_nettype none

module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  dest1;
  logic [3:0]  dest2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic [3:0]  dest_reg1;
  logic [3:0]  dest_reg2;
  logic        write_op2;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int bcnt;
  int dones;

  localparam int ZERO_LAT = 17
`ifdef MULDIV_EARLY_ZERO_EN
    - 16
`endif
    ;

  mul_div_unit #(.WIDTH(16), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .dest1(dest1), .dest2(dest2), .kill(kill), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .dest_reg1(dest_reg1),
    .dest_reg2(dest_reg2), .write_op2(write_op2), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is seen by the following rising edge.
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d1, input logic [3:0] d2);
    op = o; op_a = a; op_b = b; dest1 = d1; dest2 = d2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Latency is counted in cycles including the accept cycle.
  task automatic wait_done(output int l, output int bc);
    bc = 0;
    l  = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        l = k + 1;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00;
    op_a = '0; op_b = '0; dest1 = '0; dest2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy_done", {busy, done, write_op2, div_by_zero}, 32'h0);
    chk("reset_results", {result_hi, result_lo}, 32'h0);
    chk("reset_dests", {dest_reg2, dest_reg1}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // MULU 0xFFFF * 0xFFFF
    issue(2'b00, 16'hFFFF, 16'hFFFF, 4'd3, 4'd4);
    wait_done(lat, bcnt);
    chk("mulu_latency", lat, 17);
    chk("mulu_busy_cycles", bcnt, 16);
    chk("mulu_result", {result_hi, result_lo}, 32'hFFFE_0001);
    chk("mulu_dests", {dest_reg1, dest_reg2}, {24'h0, 4'd3, 4'd4});
    chk("mulu_wop2_dbz", {write_op2, div_by_zero}, 32'h2);
    @(negedge clk);
    chk("mulu_done_pulse", {done, write_op2}, 32'h0);
    chk("mulu_hold", {result_hi, result_lo}, 32'hFFFE_0001);

    // MULS -3 * 5, then DIVU 100/7 back-to-back in the DONE cycle
    issue(2'b01, 16'hFFFD, 16'h0005, 4'd1, 4'd2);
    wait_done(lat, bcnt);
    chk("muls_result", {result_hi, result_lo}, 32'hFFFF_FFF1);
    issue(2'b10, 16'd100, 16'd7, 4'd5, 4'd6);
    chk("b2b_done_single", {done, busy}, 32'h1);
    wait_done(lat, bcnt);
    chk("b2b_spacing", lat, 17);
    chk("divu_result", {result_hi, result_lo}, 32'h0002_000E);
    chk("divu_dests", {dest_reg1, dest_reg2}, {24'h0, 4'd5, 4'd6});
    @(negedge clk);

    // DIVS -7 / 2 and the overflow case
    issue(2'b11, 16'hFFF9, 16'h0002, 4'd7, 4'd8);
    wait_done(lat, bcnt);
    chk("divs_neg", {result_hi, result_lo}, 32'hFFFF_FFFD);
    @(negedge clk);
    issue(2'b11, 16'h8000, 16'hFFFF, 4'd7, 4'd8);
    wait_done(lat, bcnt);
    chk("divs_ovf", {result_hi, result_lo}, 32'h0000_8000);
    chk("divs_ovf_dbz", div_by_zero, 32'h0);
    @(negedge clk);

    // Multiply by zero
    issue(2'b01, 16'h1234, 16'h0000, 4'd2, 4'd3);
    wait_done(lat, bcnt);
    chk("mul0_latency", lat, ZERO_LAT);
    chk("mul0_result", {result_hi, result_lo}, 32'h0);
    chk("mul0_dbz", div_by_zero, 32'h0);
    @(negedge clk);

    // DIVU by zero
    issue(2'b10, 16'h1234, 16'h0000, 4'd9, 4'd10);
    wait_done(lat, bcnt);
    chk("div0_latency", lat, ZERO_LAT);
    chk("div0_result", {result_hi, result_lo}, 32'h1234_FFFF);
    chk("div0_dbz", div_by_zero, 32'h1);
    @(negedge clk);
    chk("div0_dbz_clear", {div_by_zero, done}, 32'h0);

    // Kill in RUN at cycle 5, with a simultaneous start
    issue(2'b00, 16'h0003, 16'h0004, 4'd1, 4'd1);
    repeat (3) @(negedge clk);
    kill = 1'b1; start = 1'b1; op = 2'b00; op_a = 16'h0002; op_b = 16'h0002;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    chk("kill_busy", busy, 32'h0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    chk("kill_no_done", dones, 32'h0);
    chk("kill_hold", {result_hi, result_lo}, 32'h1234_FFFF);

    // start together with kill in IDLE
    kill = 1'b1; start = 1'b1;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    chk("kill_idle_start", busy, 32'h0);

    // Reset in the middle of a divide
    issue(2'b10, 16'h00FF, 16'h0003, 4'd11, 4'd12);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_flags", {busy, done, write_op2, div_by_zero}, 32'h0);
    chk("rst_mid_results", {result_hi, result_lo}, 32'h0);
    chk("rst_mid_dests", {dest_reg2, dest_reg1}, 32'h0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    chk("rst_no_done", dones, 32'h0);

    // Recovery after reset
    issue(2'b00, 16'd7, 16'd9, 4'd13, 4'd14);
    wait_done(lat, bcnt);
    chk("recover_latency", lat, 17);
    chk("recover_result", {result_hi, result_lo}, 32'h0000_003F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
